// File: rtl/single_image_loader.sv
// Pixel-stream front end for single_predict_layer1: converts 8-bit pixels to p/255.0 floats,
// fills the x[] vector, pulses start and holds x until the layer reports done.
module single_image_loader #(
    parameter int LAYER1_NEURONS = 784,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [7:0]                       pix_data,
    input  logic                             pix_last,
    output logic [LAYER1_NEURONS-1:0][31:0]  x,
    output logic                             start,
    input  logic                             done,
    output logic                             busy,
    output logic                             frame_err,
    output logic [CNT_W-1:0]                 img_count
);
    localparam int IDX_W = $clog2(LAYER1_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER1_NEURONS - 1);

    // Exact p/255 as a single: normalise with the smallest k so that p*2^k >= 255,
    // then divide with round-half-up (255 is odd, so no ties exist).
    function automatic logic [31:0] p_div_255(input int p);
        int          k;
        logic [63:0] num;
        logic [63:0] q;
        if (p == 0) return 32'h0;
        k = 0;
        for (int j = 0; j < 8; j++)
            if ((p << k) < 255) k = k + 1;
        num = 64'(p) << (k + 23);
        q   = (num + 64'd127) / 64'd255;
        return {1'b0, 8'(127 - k), 23'(q - 64'h80_0000)};
    endfunction

    function automatic logic [255:0][31:0] build_lut();
        logic [255:0][31:0] t;
        for (int p = 0; p < 256; p++) t[p[7:0]] = p_div_255(p);
        return t;
    endfunction

    localparam logic [255:0][31:0] CONV_LUT = build_lut();

    typedef enum logic [1:0] {FILL, FLUSH, FIRE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              ferr_q, ferr_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer;

    logic              vld_p1_q;
    logic [31:0]       conv_p1_q;
    logic [IDX_W-1:0]  widx_p1_q;

    assign pix_ready = (state_q == FILL);
    assign xfer      = pix_valid & pix_ready;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;
    assign img_count = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        ferr_d  = 1'b0;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    busy_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = FLUSH;
                        idx_d   = '0;
                        ferr_d  = ~pix_last;
                    end else if (pix_last) begin
                        // Short frame: abandon it, keep what was written.
                        idx_d  = '0;
                        ferr_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FLUSH: state_d = FIRE;
            FIRE: begin
                state_d = WAIT;
                start_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            WAIT: begin
                if (done) begin
                    state_d = FILL;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FILL;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            vld_p1_q <= xfer;
        end
    end

    // Stage p1: converted pixel and its destination index.
    always_ff @(posedge clk) begin
        if (xfer) begin
            conv_p1_q <= CONV_LUT[pix_data];
            widx_p1_q <= idx_q;
        end
    end

    // Stage p2: commit into the image vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x <= '0;
        end else if (vld_p1_q) begin
            x[widx_p1_q] <= conv_p1_q;
        end
    end

endmodule

// File: tb/tb_single_image_loader.sv
// Randomised bench for single_image_loader against a real-arithmetic reference of the
// pixel normalisation and a frame-level model of the image vector and counters.
module tb_single_image_loader;
    localparam int N = 784;

    logic              clk = 1'b0;
    logic              rstn;
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_data;
    logic              pix_last;
    logic [N-1:0][31:0] x;
    logic              start;
    logic              done;
    logic              busy;
    logic              frame_err;
    logic [15:0]       img_count;

    int n_vec = 0;
    int n_bad = 0;
    int n_starts = 0;

    logic [31:0] ref_x [N];
    int          midx;
    int          ref_cnt;
    logic [7:0]  img [N];

    single_image_loader #(.LAYER1_NEURONS(N), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .x(x), .start(start), .done(done),
        .busy(busy), .frame_err(frame_err), .img_count(img_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) n_starts++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: scale p/255 into [1,2) by doubling, then round the 23-bit fraction.
    function automatic logic [31:0] ref_f(input int p);
        real r;
        int  e;
        int  m;
        if (p == 0) return 32'h0;
        r = p / 255.0;
        e = 0;
        while (r < 1.0) begin
            r = r * 2.0;
            e--;
        end
        m = $rtoi(r * 8388608.0 + 0.5) - 8388608;
        return {1'b0, 8'(127 + e), 23'(m)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) ref_x[i] = 32'h0;
        midx    = 0;
        ref_cnt = 0;
    endtask

    task automatic check_x(input string tag);
        for (int i = 0; i < N; i++) check($sformatf("%s x[%0d]", tag, i), x[i], ref_x[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " start"}, 32'(start), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " img_count"}, 32'(img_count), 32'd0);
        check({tag, " pix_ready"}, 32'(pix_ready), 32'd1);
        check_x(tag);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input int gap);
        bit full;
        bit shortf;
        int t;
        pix_valid = 1'b0;
        repeat (gap) tick();
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        t = 0;
        while (pix_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) check("ready_timeout", 32'(pix_ready), 32'd1);
        tick();
        pix_valid = 1'b0;
        ref_x[midx] = ref_f(int'(d));
        full   = (midx == N - 1);
        shortf = l && !full;
        midx   = (full || shortf) ? 0 : midx + 1;
        if (full) ref_cnt++;
        check("frame_err", 32'(frame_err), 32'((full && !l) || shortf));
        check("busy", 32'(busy), 32'(!shortf));
    endtask

    task automatic send_image(input int n, input int gap_max, input bit last_on_final);
        for (int i = 0; i < n; i++)
            send_beat(img[i], (i == n - 1) && last_on_final,
                      (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    endtask

    // Called right after the final transfer edge; start must be high two edges later.
    task automatic wait_start(input string tag, input bit done_in_fire);
        check({tag, " start@T+0"}, 32'(start), 32'd0);
        if (done_in_fire) done = 1'b1;
        tick();
        check({tag, " start@T+1"}, 32'(start), 32'd0);
        tick();
        done = 1'b0;
        check({tag, " start@T+2"}, 32'(start), 32'd1);
        check({tag, " img_count"}, 32'(img_count), 32'(ref_cnt & 16'hFFFF));
        tick();
        check({tag, " start@T+3"}, 32'(start), 32'd0);
        check({tag, " pix_ready wait"}, 32'(pix_ready), 32'd0);
        check({tag, " busy wait"}, 32'(busy), 32'd1);
    endtask

    task automatic pulse_done(input string tag);
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, " pix_ready after done"}, 32'(pix_ready), 32'd1);
        check({tag, " busy after done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        rstn = 1'b0; pix_valid = 1'b0; pix_data = 8'h0; pix_last = 1'b0; done = 1'b0;
        model_reset();
        #23;
        rstn = 1'b1;
        tick();
        check_reset_outputs("T1");

        // T2: saturated image, done asserted during FIRE must be ignored.
        for (int i = 0; i < N; i++) img[i] = 8'hFF;
        s0 = n_starts;
        send_image(N, 0, 1'b1);
        wait_start("T2", 1'b1);
        check("T2 start count", 32'(n_starts - s0), 32'd1);
        check("T2 x[0]", x[0], 32'h3F80_0000);
        check("T2 x[783]", x[N-1], 32'h3F80_0000);
        check_x("T2");

        // T4: hold off done for 50 cycles with pixels offered.
        pix_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            pix_data = 8'($urandom);
            pix_last = 1'($urandom);
            tick();
            check("T4 pix_ready", 32'(pix_ready), 32'd0);
            check("T4 busy", 32'(busy), 32'd1);
        end
        pix_valid = 1'b0;
        check_x("T4");
        check("T4 img_count", 32'(img_count), 32'd1);
        pulse_done("T4");

        // T3: known constants then a full 0..255 sweep; stray done in FILL is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        check("T3 ignore done busy", 32'(busy), 32'd0);
        check("T3 ignore done ready", 32'(pix_ready), 32'd1);
        img[0] = 8'd0; img[1] = 8'd1; img[2] = 8'd128;
        for (int i = 3; i < N; i++) img[i] = 8'((i - 3) % 256);
        send_image(N, 0, 1'b1);
        wait_start("T3", 1'b0);
        check("T3 x[0]", x[0], 32'h0000_0000);
        check("T3 x[1]", x[1], 32'h3B80_8081);
        check("T3 x[2]", x[2], 32'h3F00_8081);
        check_x("T3");
        pulse_done("T3");

        // T5: short frame, then a full random image.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        s0 = n_starts;
        send_image(100, 0, 1'b1);
        tick();
        check("T5 frame_err pulse width", 32'(frame_err), 32'd0);
        repeat (3) tick();
        check("T5 no start", 32'(n_starts - s0), 32'd0);
        check("T5 pix_ready", 32'(pix_ready), 32'd1);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        send_image(N, 1, 1'b1);
        wait_start("T5", 1'b0);
        check("T5 start count", 32'(n_starts - s0), 32'd1);
        check_x("T5");
        pulse_done("T5");

        // Overlong marking: pix_last missing on the final beat still fires.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        send_image(N, 0, 1'b0);
        wait_start("NOLAST", 1'b0);
        check_x("NOLAST");
        pulse_done("NOLAST");

        // T6: asynchronous reset mid-FILL.
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(1, 255));
        send_image(400, 0, 1'b0);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("T6 fill");
        #3;
        rstn = 1'b1;
        tick();

        // T6: asynchronous reset mid-WAIT.
        send_image(N, 0, 1'b1);
        wait_start("T6 pre", 1'b0);
        repeat (4) tick();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("T6 wait");
        #3;
        rstn = 1'b1;
        tick();

        // T6: three images with random valid gaps.
        s0 = n_starts;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) img[i] = 8'($urandom);
            send_image(N, 3, 1'b1);
            wait_start($sformatf("T6 img%0d", k), 1'b0);
            check_x($sformatf("T6 img%0d", k));
            pulse_done($sformatf("T6 img%0d", k));
        end
        check("T6 start count", 32'(n_starts - s0), 32'd3);
        check("T6 img_count", 32'(img_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
